// File: rtl/ddr_req_queue.sv
// ddr_req_queue
// Host-side request FIFO in front of the DDR controller. Buffers read/write
// requests, decodes the byte address into DDR4 bg/ba/row/col at issue time and
// hands one command at a time to the controller, paced by next_cmd/rw_proc.
//
// Ports:
//   clock, reset          sole clock (rising edge), async active-high reset
//   req_valid/req_ready   host push handshake (ready = count < DEPTH)
//   req_rw/addr/wdata     request payload (1 = write)
//   next_cmd, rw_proc     controller idle / controller busy
//   cmd_valid             one-cycle issue strobe
//   cmd_rw/bg/ba/row/col  registered issued command fields
//   cmd_wdata             registered issued write data
//   count                 current occupancy
//   overflow              sticky: push attempted while full
//
// Optional feature: define DDR_REQ_QUEUE_STATS_EN to add stat_rd, stat_wr
// (saturating issued read/write counters) and stat_max_count (occupancy
// high-water mark).
module ddr_req_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [31:0]              req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic                     next_cmd,
    input  logic                     rw_proc,
    output logic                     cmd_valid,
    output logic                     cmd_rw,
    output logic [1:0]               cmd_bg,
    output logic [1:0]               cmd_ba,
    output logic [14:0]              cmd_row,
    output logic [9:0]               cmd_col,
    output logic [DATA_W-1:0]        cmd_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef DDR_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]              stat_rd,
    output logic [15:0]              stat_wr,
    output logic [$clog2(DEPTH):0]   stat_max_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

    state_e state_q, state_d;

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q;

    // Storage has no reset: the pointers define what is valid.
    logic              mem_rw    [DEPTH];
    logic [31:3]       mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];

    logic              cmd_rw_q;
    logic [31:3]       cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;

    logic push, pop, launch;

    assign req_ready = (count_q < FULL);
    assign cmd_valid = (state_q == StIssue);
    assign push      = req_valid && req_ready;
    assign pop       = cmd_valid;
    // Fields are latched while leaving IDLE so they are valid during ISSUE.
    assign launch    = (state_q == StIdle) && (state_d == StIssue);

    // ---------------- Issue FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (count_q != '0 && next_cmd) state_d = StIssue;
            StIssue:    state_d = StWaitBusy;
            StWaitBusy: if (rw_proc) state_d = StWaitDone;
            StWaitDone: if (!rw_proc && next_cmd) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // ---------------- Occupancy ----------------
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (req_valid && !req_ready) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_rw[wr_ptr_q]    <= req_rw;
            mem_addr[wr_ptr_q]  <= req_addr[31:3];
            mem_wdata[wr_ptr_q] <= req_wdata;
        end
    end

    // ---------------- Issued command registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else if (launch) begin
            cmd_rw_q    <= mem_rw[rd_ptr_q];
            cmd_addr_q  <= mem_addr[rd_ptr_q];
            cmd_wdata_q <= mem_wdata[rd_ptr_q];
        end
    end

    assign cmd_rw    = cmd_rw_q;
    assign cmd_col   = cmd_addr_q[12:3];
    assign cmd_ba    = cmd_addr_q[14:13];
    assign cmd_bg    = cmd_addr_q[16:15];
    assign cmd_row   = cmd_addr_q[31:17];
    assign cmd_wdata = cmd_wdata_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef DDR_REQ_QUEUE_STATS_EN
    logic [15:0]      stat_rd_q, stat_wr_q;
    logic [CNT_W-1:0] stat_max_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_max_q <= '0;
        end else begin
            if (cmd_valid && !cmd_rw_q && stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
            if (cmd_valid &&  cmd_rw_q && stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
            if (count_q > stat_max_q) stat_max_q <= count_q;
        end
    end

    assign stat_rd        = stat_rd_q;
    assign stat_wr        = stat_wr_q;
    assign stat_max_count = stat_max_q;
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// Self-checking bench for ddr_req_queue: a queue-based reference model plus a
// simple controller model that answers each strobe with an rw_proc pulse.
module tb_ddr_req_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_rw = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              next_cmd = 1'b0;
    logic              rw_proc = 1'b0;
    logic              cmd_valid;
    logic              cmd_rw;
    logic [1:0]        cmd_bg, cmd_ba;
    logic [14:0]       cmd_row;
    logic [9:0]        cmd_col;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        count;
    logic              overflow;
`ifdef DDR_REQ_QUEUE_STATS_EN
    logic [15:0]       stat_rd, stat_wr;
    logic [3:0]        stat_max_count;
`endif

    ddr_req_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .next_cmd  (next_cmd),
        .rw_proc   (rw_proc),
        .cmd_valid (cmd_valid),
        .cmd_rw    (cmd_rw),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_wdata (cmd_wdata),
        .count     (count),
        .overflow  (overflow)
`ifdef DDR_REQ_QUEUE_STATS_EN
        ,
        .stat_rd        (stat_rd),
        .stat_wr        (stat_wr),
        .stat_max_count (stat_max_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              rw;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t mq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_ovf = 0;
    int   busy = 0;
    int   busy_len = 4;     // 0 = random pulse length per command
    int   since_strobe = 100;
    int   strobes = 0;
    int   model_rd = 0;
    int   model_wr = 0;
    int   peak = 0;

    // One clock: model push/pop bookkeeping, strobe scoreboard, controller model.
    task automatic step();
        req_t h;
        bit   push_ok, pop;
        push_ok = req_valid && (mq.size() < DEPTH);
        pop     = cmd_valid;
        if (req_valid && mq.size() >= DEPTH) exp_ovf = 1;
        if (pop) begin
            n_tests++;
            if (mq.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_empty: cmd_valid=1, required 0 (model queue empty)");
            end else begin
                h = mq.pop_front();
                if (h.rw) model_wr++; else model_rd++;
                if ({cmd_rw, cmd_bg, cmd_ba, cmd_row, cmd_col} !==
                    {h.rw, h.addr[16:15], h.addr[14:13], h.addr[31:17], h.addr[12:3]} ||
                    (h.rw && cmd_wdata !== h.wdata)) begin
                    n_fail++;
                    $display("FAIL strobe_fields: got rw=%0b bg=%0d ba=%0d row=%h col=%h wd=%h, required rw=%0b addr=%h wd=%h",
                             cmd_rw, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_wdata, h.rw, h.addr, h.wdata);
                end
            end
            n_tests++;
            if (since_strobe < 3) begin
                n_fail++;
                $display("FAIL strobe_gap: gap=%0d, required >=3", since_strobe);
            end
            since_strobe = 0;
            strobes++;
        end
        if (push_ok) mq.push_back('{req_rw, req_addr, req_wdata});
        if (mq.size() > peak) peak = mq.size();
        @(posedge clock);
        #1;
        since_strobe++;
        if (pop) busy = (busy_len == 0) ? int'($urandom_range(1, 4)) : busy_len;
        rw_proc = (busy > 0);
        if (busy > 0) busy--;
    endtask

    task automatic drive_req(input bit rw, input logic [31:0] addr);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            drive_req(1'($urandom_range(0, 1)), $urandom);
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain_all(input string name, input int exp_strobes);
        int start = strobes;
        int cyc = 0;
        next_cmd = 1'b1;
        while (mq.size() != 0 && cyc < 300) begin
            step();
            cyc++;
        end
        for (int i = 0; i < 8; i++) step();
        n_tests++;
        if (strobes - start !== exp_strobes || count !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_drain: strobes=%0d count=%0d, required strobes=%0d count=0",
                     name, strobes - start, count, exp_strobes);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        next_cmd = 1'b0;
        rw_proc = 1'b0;
        busy = 0;
        mq.delete();
        exp_ovf = 0;
        peak = 0;
        model_rd = 0;
        model_wr = 0;
        since_strobe = 100;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (count !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d, required 0", count);
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
        n_tests++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: valid=%b ovf=%b, required 0 0", cmd_valid, overflow);
        end
        n_tests++;
        if ({cmd_rw, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_cmd: got nonzero cmd fields, required all 0");
        end
    endtask

    task automatic test_single();
        do_reset();
        busy_len = 4;
        next_cmd = 1'b1;
        drive_req(1'b1, 32'h0003_A5F8);
        step();
        req_valid = 1'b0;
        n_tests++;
        if (count !== 4'd1 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_n1: count=%0d valid=%b, required 1 0", count, cmd_valid);
        end
        step();
        n_tests++;
        if (cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_latency: valid=%b, required 1", cmd_valid);
        end
        // 0x3A5F8: row=1, bg=addr[16:15]=3, ba=addr[14:13]=1, col=0x0BF
        n_tests++;
        if (cmd_row !== 15'd1 || cmd_bg !== 2'd3 || cmd_ba !== 2'd1 ||
            cmd_col !== 10'h0BF || cmd_rw !== 1'b1) begin
            n_fail++;
            $display("FAIL single_decode: row=%0d bg=%0d ba=%0d col=%h rw=%b, required 1 3 1 0bf 1",
                     cmd_row, cmd_bg, cmd_ba, cmd_col, cmd_rw);
        end
        drain_all("single", 1);
    endtask

    task automatic test_overflow();
        do_reset();
        busy_len = 4;
        fill(9);
        n_tests++;
        if (count !== 4'd8 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: count=%0d ready=%b, required 8 0", count, req_ready);
        end
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            n_fail++; $display("FAIL ovf_sticky: ovf=%b count=%0d, required 1 8", overflow, count);
        end
        drain_all("ovf", 8);
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_hold: ovf=%b, required 1", overflow);
        end
    endtask

    task automatic test_wrap();
        next_cmd = 1'b0;
        fill(3);
        drain_all("wrap3", 3);
        next_cmd = 1'b0;
        fill(8);
        drain_all("wrap8", 8);
    endtask

    task automatic test_full_pop();
        do_reset();
        busy_len = 4;
        fill(8);
        next_cmd = 1'b1;
        step();
        n_tests++;
        if (cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL fullpop_strobe: valid=%b, required 1", cmd_valid);
        end
        drive_req(1'b0, $urandom);
        step();
        req_valid = 1'b0;
        n_tests++;
        if (count !== 4'd7 || req_ready !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop_count: count=%0d ready=%b ovf=%b, required 7 1 1", count, req_ready, overflow);
        end
        drain_all("fullpop", 7);
    endtask

    task automatic test_reset_mid();
        do_reset();
        busy_len = 50;
        fill(4);
        next_cmd = 1'b1;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (cmd_valid !== 1'b0 || count !== 4'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b count=%0d ready=%b, required 0 0 1", cmd_valid, count, req_ready);
        end
        mq.delete();
        busy = 0;
        rw_proc = 1'b0;
        busy_len = 4;
        exp_ovf = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        since_strobe = 100;
        for (int i = 0; i < 10; i++) step();
        n_tests++;
        if (count !== 4'd0 || strobes < 0) begin
            n_fail++; $display("FAIL midreset_quiet: count=%0d, required 0", count);
        end
        drive_req(1'b0, $urandom);
        step();
        req_valid = 1'b0;
        step();
        n_tests++;
        if (cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL midreset_reissue: valid=%b, required 1", cmd_valid);
        end
        drain_all("midreset", 1);
    endtask

    task automatic test_random();
        do_reset();
        busy_len = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 45) drive_req(1'($urandom_range(0, 1)), $urandom);
            else req_valid = 1'b0;
            next_cmd = ($urandom_range(0, 99) < 70);
            step();
            n_tests++;
            if (count !== 4'(mq.size()) || req_ready !== (mq.size() < DEPTH) || overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: count=%0d ready=%b ovf=%b, required %0d %b %b",
                         i, count, req_ready, overflow, mq.size(), mq.size() < DEPTH, exp_ovf);
            end
        end
        req_valid = 1'b0;
        drain_all("rand", mq.size() + (cmd_valid ? 0 : 0));
        busy_len = 4;
    endtask

`ifdef DDR_REQ_QUEUE_STATS_EN
    task automatic test_stats();
        do_reset();
        busy_len = 4;
        for (int i = 0; i < 5; i++) begin
            drive_req(i >= 3, $urandom);
            step();
        end
        req_valid = 1'b0;
        drain_all("stats", 5);
        n_tests++;
        if (stat_rd !== 16'(model_rd) || stat_wr !== 16'(model_wr) || stat_max_count !== 4'(peak)) begin
            n_fail++;
            $display("FAIL stats: rd=%0d wr=%0d max=%0d, required %0d %0d %0d",
                     stat_rd, stat_wr, stat_max_count, model_rd, model_wr, peak);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_full_pop();
        test_reset_mid();
        test_random();
`ifdef DDR_REQ_QUEUE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
